vx_stream_rsp_router: RTL and testbench

// - Sits directly downstream of a many-to-one stream arbiter: forwards the arbitrated request stream unchanged and records its sel tag.
// - Steers the in-order response stream back to the original requester port.
// - Bounds in-flight requests to MAX_PENDING using an internal tag FIFO.
// - Used between per-core request arbitration and an in-order memory/service port.

---
 rtl/vx_stream_rsp_router_if.sv | 40 ++++
 rtl/vx_stream_rsp_router.sv | 102 ++++++++++
 tb/tb_vx_stream_rsp_router.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_stream_rsp_router_if.sv
// Handshake bundle for vx_stream_rsp_router: request in/out, response in/out and occupancy.
// The router takes the slave view; the driving environment takes the master view.
interface vx_stream_rsp_router_if #(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned REQ_DATAW   = 32,
  parameter int unsigned RSP_DATAW   = 32,
  parameter int unsigned MAX_PENDING = 8
);
  localparam int unsigned SEL_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  logic                          req_valid_in;
  logic [REQ_DATAW-1:0]          req_data_in;
  logic [SEL_W-1:0]              req_sel_in;
  logic                          req_ready_in;
  logic                          req_valid_out;
  logic [REQ_DATAW-1:0]          req_data_out;
  logic                          req_ready_out;
  logic                          rsp_valid_in;
  logic [RSP_DATAW-1:0]          rsp_data_in;
  logic                          rsp_ready_in;
  logic [NUM_REQS-1:0]           rsp_valid_out;
  logic [NUM_REQS*RSP_DATAW-1:0] rsp_data_out;
  logic [NUM_REQS-1:0]           rsp_ready_out;
  logic [PEND_W-1:0]             pending_count;

  modport slave (
    input  req_valid_in, req_data_in, req_sel_in, req_ready_out,
    input  rsp_valid_in, rsp_data_in, rsp_ready_out,
    output req_ready_in, req_valid_out, req_data_out,
    output rsp_ready_in, rsp_valid_out, rsp_data_out, pending_count
  );

  modport master (
    output req_valid_in, req_data_in, req_sel_in, req_ready_out,
    output rsp_valid_in, rsp_data_in, rsp_ready_out,
    input  req_ready_in, req_valid_out, req_data_out,
    input  rsp_ready_in, rsp_valid_out, rsp_data_out, pending_count
  );
endinterface

// File: rtl/vx_stream_rsp_router.sv
// Forwards an arbitrated request stream and steers in-order responses back to the requester
// whose sel tag was recorded in a bounded tag FIFO.
module vx_stream_rsp_router #(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned REQ_DATAW   = 32,
  parameter int unsigned RSP_DATAW   = 32,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  vx_stream_rsp_router_if.slave   bus
);
  localparam int unsigned SEL_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int unsigned SELX_W = SEL_W + 1;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

  logic [SEL_W-1:0]     tag_q [MAX_PENDING];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PEND_W-1:0]    count_q, count_d;
  logic                 out_v_q, out_v_d;
  logic [SEL_W-1:0]     out_sel_q, out_sel_d;
  logic [RSP_DATAW-1:0] out_data_q, out_data_d;
  logic [REQ_DATAW-1:0] req_data;
  logic                 full, empty, slot_free, req_fire, rsp_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full/empty come from the registered count only, so a same-cycle pop never unblocks a push.
  assign full      = (count_q == PEND_W'(MAX_PENDING));
  assign empty     = (count_q == '0);
  assign slot_free = ~out_v_q | bus.rsp_ready_out[out_sel_q];

  assign req_data          = bus.req_data_in;
  assign bus.req_data_out  = req_data;
  assign bus.req_valid_out = reset & bus.req_valid_in & ~full;
  assign bus.req_ready_in  = reset & bus.req_ready_out & ~full;
  assign bus.rsp_ready_in  = reset & ~empty & slot_free;
  assign bus.pending_count = count_q;
  assign bus.rsp_data_out  = {NUM_REQS{out_data_q}};

  assign req_fire = bus.req_valid_in & bus.req_ready_in;
  assign rsp_fire = bus.rsp_valid_in & bus.rsp_ready_in;

  always_comb begin
    bus.rsp_valid_out = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      bus.rsp_valid_out[i] = out_v_q && (out_sel_q == SEL_W'(i));
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_v_d    = out_v_q;
    out_sel_d  = out_sel_q;
    out_data_d = out_data_q;
    if (req_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rsp_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({req_fire, rsp_fire})
      2'b10:   count_d = count_q + PEND_W'(1);
      2'b01:   count_d = count_q - PEND_W'(1);
      default: count_d = count_q;
    endcase
    if (rsp_fire) begin
      out_v_d    = 1'b1;
      out_sel_d  = tag_q[rd_ptr_q];
      out_data_d = bus.rsp_data_in;
    end else if (out_v_q && bus.rsp_ready_out[out_sel_q]) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_v_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_v_q    <= out_v_d;
      out_sel_q  <= out_sel_d;
      out_data_q <= out_data_d;
    end
  end

  // Tag storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (req_fire) tag_q[wr_ptr_q] <= bus.req_sel_in;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) req_fire |-> !full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) rsp_fire |-> !empty);
  a_sel_range:    assert property (@(posedge clk) disable iff (!reset)
                                   req_fire |-> ({1'b0, bus.req_sel_in} < SELX_W'(NUM_REQS)));
endmodule

// File: tb/tb_vx_stream_rsp_router.sv
// Directed bench for vx_stream_rsp_router: one instance with 8 pending slots, one with 5
// to exercise non-power-of-2 pointer wrap.
module tb_vx_stream_rsp_router;
  logic clk;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  vx_stream_rsp_router_if #(.NUM_REQS(4), .REQ_DATAW(32), .RSP_DATAW(32), .MAX_PENDING(8)) ifa ();
  vx_stream_rsp_router_if #(.NUM_REQS(4), .REQ_DATAW(32), .RSP_DATAW(32), .MAX_PENDING(5)) ifb ();

  vx_stream_rsp_router #(.NUM_REQS(4), .REQ_DATAW(32), .RSP_DATAW(32), .MAX_PENDING(8)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  vx_stream_rsp_router #(.NUM_REQS(4), .REQ_DATAW(32), .RSP_DATAW(32), .MAX_PENDING(5)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.req_valid_in = 0; ifa.req_data_in = '0; ifa.req_sel_in = '0; ifa.req_ready_out = 1;
    ifa.rsp_valid_in = 0; ifa.rsp_data_in = '0; ifa.rsp_ready_out = 4'hF;
    ifb.req_valid_in = 0; ifb.req_data_in = '0; ifb.req_sel_in = '0; ifb.req_ready_out = 1;
    ifb.rsp_valid_in = 0; ifb.rsp_data_in = '0; ifb.rsp_ready_out = 4'hF;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_a = 0; rst_b = 0;
    ifa.req_valid_in = 1; ifa.rsp_valid_in = 1;
    #1;
    checks++;
    if ({ifa.req_ready_in, ifa.req_valid_out, ifa.rsp_ready_in} !== 3'b000) begin
      errors++;
      $display("FAIL reset_force got %b exp 000",
               {ifa.req_ready_in, ifa.req_valid_out, ifa.rsp_ready_in});
    end
    cyc(); cyc();
    rst_a = 1; rst_b = 1;
    #1;
    checks++;
    if (ifa.pending_count !== 4'd0 || ifa.rsp_valid_out !== 4'b0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d v=%b exp cnt=0 v=0000",
               ifa.pending_count, ifa.rsp_valid_out);
    end
    checks++;
    if (ifa.req_valid_out !== 1'b1 || ifa.rsp_ready_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_follow got vout=%b rrdy=%b exp 1 0", ifa.req_valid_out,
               ifa.rsp_ready_in);
    end
    ifa.req_valid_in = 0;
    #1;
    checks++;
    if (ifa.req_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_follow0 got %b exp 0", ifa.req_valid_out);
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_order();
    logic [1:0]  sels [4];
    logic [3:0]  exp_v [4];
    logic [31:0] dat [4];
    sels = '{2'd2, 2'd0, 2'd3, 2'd1};
    exp_v = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    dat = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    for (int i = 0; i < 4; i++) begin
      ifa.req_valid_in = 1; ifa.req_sel_in = sels[i]; ifa.req_data_in = 32'h1000 + i;
      #1;
      checks++;
      if (ifa.req_ready_in !== 1'b1 || ifa.req_data_out !== 32'h1000 + i) begin
        errors++;
        $display("FAIL order_req%0d got rdy=%b d=%h exp rdy=1 d=%h", i, ifa.req_ready_in,
                 ifa.req_data_out, 32'h1000 + i);
      end
      cyc();
    end
    ifa.req_valid_in = 0;
    checks++;
    if (ifa.pending_count !== 4'd4) begin
      errors++;
      $display("FAIL order_pending got %0d exp 4", ifa.pending_count);
    end
    for (int i = 0; i < 4; i++) begin
      ifa.rsp_valid_in = 1; ifa.rsp_data_in = dat[i];
      cyc();
      checks++;
      if (ifa.rsp_valid_out !== exp_v[i] || ifa.rsp_data_out !== {4{dat[i]}}) begin
        errors++;
        $display("FAIL order_rsp%0d got v=%b d=%h exp v=%b d=%h", i, ifa.rsp_valid_out,
                 ifa.rsp_data_out[31:0], exp_v[i], dat[i]);
      end
    end
    ifa.rsp_valid_in = 0;
    cyc();
    checks++;
    if (ifa.rsp_valid_out !== 4'b0 || ifa.pending_count !== 4'd0) begin
      errors++;
      $display("FAIL order_drain got v=%b cnt=%0d exp 0000 0", ifa.rsp_valid_out,
               ifa.pending_count);
    end
  endtask

  task automatic test_full();
    int accepts = 0;
    for (int k = 0; k < 10; k++) begin
      ifa.req_valid_in = 1; ifa.req_sel_in = 2'(k);
      #1;
      if (ifa.req_ready_in) accepts++;
      cyc();
    end
    checks++;
    if (accepts != 8 || ifa.req_ready_in !== 1'b0 || ifa.req_valid_out !== 1'b0 ||
        ifa.pending_count !== 4'd8) begin
      errors++;
      $display("FAIL full_block got acc=%0d rdy=%b vout=%b cnt=%0d exp 8 0 0 8", accepts,
               ifa.req_ready_in, ifa.req_valid_out, ifa.pending_count);
    end
    ifa.rsp_valid_in = 1; ifa.rsp_data_in = 32'hF00D;
    #1;
    checks++;
    if (ifa.rsp_ready_in !== 1'b1 || ifa.req_ready_in !== 1'b0) begin
      errors++;
      $display("FAIL full_nobypass got rrdy=%b qrdy=%b exp 1 0", ifa.rsp_ready_in,
               ifa.req_ready_in);
    end
    cyc();
    ifa.rsp_valid_in = 0; ifa.req_valid_in = 0;
    #1;
    checks++;
    if (ifa.pending_count !== 4'd7 || ifa.req_ready_in !== 1'b1 ||
        ifa.rsp_valid_out !== 4'b0001) begin
      errors++;
      $display("FAIL full_reopen got cnt=%0d rdy=%b v=%b exp 7 1 0001", ifa.pending_count,
               ifa.req_ready_in, ifa.rsp_valid_out);
    end
    ifa.rsp_valid_in = 1;
    repeat (7) cyc();
    ifa.rsp_valid_in = 0;
    cyc();
    checks++;
    if (ifa.pending_count !== 4'd0 || ifa.rsp_valid_out !== 4'b0) begin
      errors++;
      $display("FAIL full_drain got cnt=%0d v=%b exp 0 0000", ifa.pending_count,
               ifa.rsp_valid_out);
    end
  endtask

  task automatic test_backpressure();
    ifa.req_valid_in = 1; ifa.req_sel_in = 2'd1;
    cyc();
    ifa.req_sel_in = 2'd2;
    cyc();
    ifa.req_valid_in = 0;
    ifa.rsp_ready_out = 4'b1101;
    ifa.rsp_valid_in = 1; ifa.rsp_data_in = 32'h0000_00B1;
    cyc();
    ifa.rsp_data_in = 32'h0000_00C2;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (ifa.rsp_ready_in !== 1'b0 || ifa.rsp_valid_out !== 4'b0010 ||
          ifa.rsp_data_out[63:32] !== 32'hB1 || ifa.pending_count !== 4'd1) begin
        errors++;
        $display("FAIL bp_hold%0d got rrdy=%b v=%b d=%h cnt=%0d exp 0 0010 b1 1", k,
                 ifa.rsp_ready_in, ifa.rsp_valid_out, ifa.rsp_data_out[63:32],
                 ifa.pending_count);
      end
      cyc();
    end
    ifa.rsp_ready_out = 4'hF;
    #1;
    checks++;
    if (ifa.rsp_ready_in !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %b exp 1", ifa.rsp_ready_in);
    end
    cyc();
    ifa.rsp_valid_in = 0;
    checks++;
    if (ifa.rsp_valid_out !== 4'b0100 || ifa.rsp_data_out[95:64] !== 32'hC2 ||
        ifa.pending_count !== 4'd0) begin
      errors++;
      $display("FAIL bp_next got v=%b d=%h cnt=%0d exp 0100 c2 0", ifa.rsp_valid_out,
               ifa.rsp_data_out[95:64], ifa.pending_count);
    end
    cyc();
    checks++;
    if (ifa.rsp_valid_out !== 4'b0) begin
      errors++;
      $display("FAIL bp_drain got %b exp 0000", ifa.rsp_valid_out);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_v [3];
    exp_v = '{4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      ifa.req_valid_in = 1; ifa.req_sel_in = 2'(k);
      cyc();
    end
    ifa.req_sel_in = 2'd3;
    ifa.rsp_valid_in = 1; ifa.rsp_data_in = 32'h55;
    #1;
    checks++;
    if (ifa.req_ready_in !== 1'b1 || ifa.rsp_ready_in !== 1'b1) begin
      errors++;
      $display("FAIL sim_both got q=%b r=%b exp 1 1", ifa.req_ready_in, ifa.rsp_ready_in);
    end
    cyc();
    ifa.req_valid_in = 0; ifa.rsp_valid_in = 0;
    checks++;
    if (ifa.pending_count !== 4'd3 || ifa.rsp_valid_out !== 4'b0001) begin
      errors++;
      $display("FAIL sim_count got cnt=%0d v=%b exp 3 0001", ifa.pending_count,
               ifa.rsp_valid_out);
    end
    ifa.rsp_valid_in = 1;
    for (int k = 0; k < 3; k++) begin
      ifa.rsp_data_in = 32'h60 + k;
      cyc();
      checks++;
      if (ifa.rsp_valid_out !== exp_v[k] || ifa.rsp_data_out[31:0] !== 32'h60 + k) begin
        errors++;
        $display("FAIL sim_rsp%0d got v=%b d=%h exp %b %h", k, ifa.rsp_valid_out,
                 ifa.rsp_data_out[31:0], exp_v[k], 32'h60 + k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ifa.rsp_ready_in !== 1'b0) begin
        errors++;
        $display("FAIL sim_empty%0d got %b exp 0", k, ifa.rsp_ready_in);
      end
      cyc();
    end
    checks++;
    if (ifa.rsp_valid_out !== 4'b0 || ifa.pending_count !== 4'd0) begin
      errors++;
      $display("FAIL sim_empty_out got v=%b cnt=%0d exp 0000 0", ifa.rsp_valid_out,
               ifa.pending_count);
    end
    // A tag pushed this cycle must not be poppable until the next one.
    ifa.req_valid_in = 1; ifa.req_sel_in = 2'd2; ifa.rsp_data_in = 32'h77;
    #1;
    checks++;
    if (ifa.rsp_ready_in !== 1'b0) begin
      errors++;
      $display("FAIL sim_push_pop_same got %b exp 0", ifa.rsp_ready_in);
    end
    cyc();
    ifa.req_valid_in = 0;
    #1;
    checks++;
    if (ifa.rsp_ready_in !== 1'b1) begin
      errors++;
      $display("FAIL sim_push_pop_next got %b exp 1", ifa.rsp_ready_in);
    end
    cyc();
    ifa.rsp_valid_in = 0;
    checks++;
    if (ifa.rsp_valid_out !== 4'b0100 || ifa.rsp_data_out[31:0] !== 32'h77) begin
      errors++;
      $display("FAIL sim_late_pop got v=%b d=%h exp 0100 77", ifa.rsp_valid_out,
               ifa.rsp_data_out[31:0]);
    end
    cyc();
  endtask

  task automatic test_wrap_reset();
    logic [1:0] sel_q [$];
    logic [1:0] s;
    for (int c = 0; c < 14; c++) begin
      ifb.req_valid_in = (c < 12);
      ifb.req_sel_in   = 2'((c * 3 + 1) % 4);
      ifb.rsp_valid_in = (c >= 2);
      ifb.rsp_data_in  = 32'hA00 + c - 2;
      #1;
      checks++;
      if ((c < 12 && ifb.req_ready_in !== 1'b1) || (c >= 2 && ifb.rsp_ready_in !== 1'b1)) begin
        errors++;
        $display("FAIL wrap_rdy%0d got q=%b r=%b exp ready", c, ifb.req_ready_in,
                 ifb.rsp_ready_in);
      end
      if (c < 12) sel_q.push_back(2'((c * 3 + 1) % 4));
      cyc();
      if (c >= 2) begin
        s = sel_q.pop_front();
        checks++;
        if (ifb.rsp_valid_out !== (4'b1 << s) || ifb.rsp_data_out[31:0] !== 32'hA00 + c - 2) begin
          errors++;
          $display("FAIL wrap_rsp%0d got v=%b d=%h exp %b %h", c - 2, ifb.rsp_valid_out,
                   ifb.rsp_data_out[31:0], 4'b1 << s, 32'hA00 + c - 2);
        end
      end
    end
    ifb.req_valid_in = 0; ifb.rsp_valid_in = 0;
    cyc();
    checks++;
    if (ifb.pending_count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_end got %0d exp 0", ifb.pending_count);
    end
    // Four requests, one response held on a blocked lane, three tags still pending.
    for (int k = 0; k < 4; k++) begin
      ifb.req_valid_in = 1; ifb.req_sel_in = 2'(k + 1);
      cyc();
    end
    ifb.req_valid_in = 0;
    ifb.rsp_ready_out = 4'b0000;
    ifb.rsp_valid_in = 1; ifb.rsp_data_in = 32'hDEAD;
    cyc();
    ifb.rsp_valid_in = 0;
    checks++;
    if (ifb.pending_count !== 3'd3 || ifb.rsp_valid_out !== 4'b0010) begin
      errors++;
      $display("FAIL rst_pre got cnt=%0d v=%b exp 3 0010", ifb.pending_count,
               ifb.rsp_valid_out);
    end
    rst_b = 0;
    cyc();
    rst_b = 1;
    ifb.rsp_ready_out = 4'hF;
    ifb.rsp_valid_in = 1; ifb.rsp_data_in = 32'hBEEF;
    #1;
    checks++;
    if (ifb.pending_count !== 3'd0 || ifb.rsp_valid_out !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid got cnt=%0d v=%b exp 0 0000", ifb.pending_count,
               ifb.rsp_valid_out);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ifb.rsp_ready_in !== 1'b0) begin
        errors++;
        $display("FAIL rst_late%0d got %b exp 0", k, ifb.rsp_ready_in);
      end
      cyc();
    end
    ifb.rsp_valid_in = 0;
    checks++;
    if (ifb.rsp_valid_out !== 4'b0) begin
      errors++;
      $display("FAIL rst_late_out got %b exp 0000", ifb.rsp_valid_out);
    end
  endtask

  initial begin
    rst_a = 0;
    rst_b = 0;
    idle_inputs();
    test_reset();
    test_order();
    test_full();
    test_backpressure();
    test_simultaneous();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
